// File: rtl/foc_pkg.sv
// Shared FOC definitions.
// Setpoint waveform modes and slew-limit constants.
package foc_pkg;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        CONST  = 2'd1,
        SQUARE = 2'd2,
        PULSE  = 2'd3
    } setpoint_mode_t;

    localparam int SLEW_OFF = 0;

endpackage

// File: rtl/slew_limiter.sv
// Combinational rate limiter.
// Moves cur toward target by at most slew per step.
module slew_limiter
    import foc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] target,
    input  logic signed [WIDTH-1:0] cur,
    input  logic        [WIDTH-2:0] slew,
    output logic signed [WIDTH-1:0] next
);

    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] stepped;
    logic        [WIDTH:0] mag;
    logic        [WIDTH:0] slew_x;

    always_comb begin
        diff   = {target[WIDTH-1], target} - {cur[WIDTH-1], cur};
        mag    = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        slew_x = {2'b00, slew};
        if (diff[WIDTH]) begin
            stepped = {cur[WIDTH-1], cur} - $signed(slew_x);
        end else begin
            stepped = {cur[WIDTH-1], cur} + $signed(slew_x);
        end
        if (slew == (WIDTH-1)'(SLEW_OFF) || mag <= slew_x) begin
            next = target;
        end else begin
            next = stepped[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/iq_setpoint_gen.sv
// Iq setpoint generator: ZERO/CONST/SQUARE/PULSE waveforms
// advanced on control ticks, with optional slew limiting.
module iq_setpoint_gen
    import foc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PERIOD_W = 24
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_en,
    input  logic                    i_clr,
    input  logic [1:0]              i_mode,
    input  logic [WIDTH-2:0]        i_amp,
    input  logic [PERIOD_W-1:0]     i_half_period,
    input  logic [WIDTH-2:0]        i_slew,
    output logic signed [WIDTH-1:0] o_aim,
    output logic                    o_valid,
    output logic                    o_dir
);

    logic [PERIOD_W-1:0]     phase_cnt;
    logic [PERIOD_W-1:0]     phase_nx;
    logic [PERIOD_W-1:0]     term;
    logic                    dir_nx;
    logic                    restart;
    logic                    started;
    setpoint_mode_t          mode_q;
    setpoint_mode_t          mode_in;
    logic signed [WIDTH-1:0] amp_s;
    logic signed [WIDTH-1:0] target;
    logic signed [WIDTH-1:0] aim_nx;

    assign mode_in = setpoint_mode_t'(i_mode);
    assign amp_s   = $signed({1'b0, i_amp});

    // The first tick after reset adopts the mode without restarting,
    // so a SQUARE run from reset opens on its negative half-cycle.
    assign restart = started && (mode_in != mode_q);

    always_comb begin
        term     = '0;
        phase_nx = '0;
        dir_nx   = o_dir;
        if (i_half_period != '0) begin
            term = i_half_period - PERIOD_W'(1);
        end
        if (restart) begin
            phase_nx = '0;
            dir_nx   = 1'b1;
        end else if (phase_cnt >= term) begin
            phase_nx = '0;
            dir_nx   = ~o_dir;
        end else begin
            phase_nx = phase_cnt + PERIOD_W'(1);
            dir_nx   = o_dir;
        end
    end

    always_comb begin
        target = '0;
        unique case (mode_in)
            ZERO:   target = '0;
            CONST:  target = amp_s;
            SQUARE: target = dir_nx ? amp_s : -amp_s;
            PULSE:  target = dir_nx ? amp_s : '0;
        endcase
    end

    slew_limiter #(
        .WIDTH (WIDTH)
    ) u_slew (
        .target (target),
        .cur    (o_aim),
        .slew   (i_slew),
        .next   (aim_nx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_cnt <= '0;
            o_dir     <= 1'b0;
            o_aim     <= '0;
            o_valid   <= 1'b0;
            mode_q    <= ZERO;
            started   <= 1'b0;
        end else begin
            o_valid <= i_en | i_clr;
            if (i_clr) begin
                phase_cnt <= '0;
                o_dir     <= 1'b0;
                o_aim     <= '0;
            end else if (i_en) begin
                phase_cnt <= phase_nx;
                o_dir     <= dir_nx;
                o_aim     <= aim_nx;
                mode_q    <= mode_in;
                started   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iq_setpoint_gen.sv
// Bench for iq_setpoint_gen: vector tables feeding a scoreboard
// queue, plus hand sequences for clear and async reset.
module tb_iq_setpoint_gen;

    localparam int WIDTH    = 16;
    localparam int PERIOD_W = 24;

    logic                    clk;
    logic                    rstn;
    logic                    i_en;
    logic                    i_clr;
    logic [1:0]              i_mode;
    logic [WIDTH-2:0]        i_amp;
    logic [PERIOD_W-1:0]     i_half_period;
    logic [WIDTH-2:0]        i_slew;
    logic signed [WIDTH-1:0] o_aim;
    logic                    o_valid;
    logic                    o_dir;

    iq_setpoint_gen #(
        .WIDTH    (WIDTH),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_en          (i_en),
        .i_clr         (i_clr),
        .i_mode        (i_mode),
        .i_amp         (i_amp),
        .i_half_period (i_half_period),
        .i_slew        (i_slew),
        .o_aim         (o_aim),
        .o_valid       (o_valid),
        .o_dir         (o_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit en;
        bit clr;
        int mode;
        int amp;
        int hp;
        int slew;
        int exp_aim;
        bit exp_dir;
    } vec_t;

    typedef struct {
        int aim;
        bit dir;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam int M_ZERO = 0;
    localparam int M_CONST = 1;
    localparam int M_SQ = 2;
    localparam int M_PULSE = 3;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit en, bit clr, int mode, int amp,
                                int hp, int slew, int ea, bit ed);
        vec_t v;
        v.en = en;
        v.clr = clr;
        v.mode = mode;
        v.amp = amp;
        v.hp = hp;
        v.slew = slew;
        v.exp_aim = ea;
        v.exp_dir = ed;
        return v;
    endfunction

    // Apply the table one cycle per record; the scoreboard is
    // popped whenever the DUT flags an update.
    task automatic run_vecs(input string tag);
        exp_t e;
        int   aim;
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            i_en          = vecs[k].en;
            i_clr         = vecs[k].clr;
            i_mode        = 2'(vecs[k].mode);
            i_amp         = 15'(vecs[k].amp);
            i_half_period = 24'(vecs[k].hp);
            i_slew        = 15'(vecs[k].slew);
            if (vecs[k].en || vecs[k].clr) begin
                e.aim = vecs[k].exp_aim;
                e.dir = vecs[k].exp_dir;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].valid", tag, k),
                int'(o_valid), int'(sb.size() != 0));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (o_valid) begin
                    aim = o_aim;
                    chk($sformatf("%s[%0d].aim", tag, k), aim, e.aim);
                    chk($sformatf("%s[%0d].dir", tag, k), int'(o_dir), int'(e.dir));
                end
            end
        end
        vecs.delete();
        @(negedge clk);
        i_en  = 1'b0;
        i_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn  = 1'b0;
        i_en  = 1'b0;
        i_clr = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int aim;
        rstn          = 1'b0;
        i_en          = 1'b0;
        i_clr         = 1'b0;
        i_mode        = '0;
        i_amp         = '0;
        i_half_period = '0;
        i_slew        = '0;
        repeat (2) @(negedge clk);
        aim = o_aim;
        chk("reset.aim", aim, 0);
        chk("reset.valid", int'(o_valid), 0);
        chk("reset.dir", int'(o_dir), 0);
        rstn = 1'b1;

        // SQUARE amp 200, half period 4, no slew
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, M_SQ, 200, 4, 0, -200, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, M_SQ, 200, 4, 0, 200, 1));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, M_SQ, 200, 4, 0, -200, 0));
        vecs.push_back(mk(1, 0, M_SQ, 200, 4, 0, 200, 1));
        run_vecs("square");

        // SQUARE with slew 50 across a wrap
        do_reset();
        vecs.push_back(mk(1, 0, M_SQ, 200, 100, 50, -50, 0));
        vecs.push_back(mk(1, 0, M_SQ, 200, 100, 50, -100, 0));
        vecs.push_back(mk(1, 0, M_SQ, 200, 100, 50, -150, 0));
        for (int k = 0; k < 96; k++) vecs.push_back(mk(1, 0, M_SQ, 200, 100, 50, -200, 0));
        for (int k = 0; k < 8; k++) vecs.push_back(mk(1, 0, M_SQ, 200, 100, 50, -150 + 50 * k, 1));
        vecs.push_back(mk(1, 0, M_SQ, 200, 100, 50, 200, 1));
        run_vecs("slew");

        // PULSE with idle cycles between ticks, then clear and mode changes
        do_reset();
        vecs.push_back(mk(1, 0, M_PULSE, 1000, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, M_PULSE, 1000, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, M_PULSE, 1000, 2, 0, 1000, 1));
        vecs.push_back(mk(1, 0, M_PULSE, 1000, 2, 0, 1000, 1));
        vecs.push_back(mk(0, 0, M_PULSE, 1000, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, M_PULSE, 1000, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, M_PULSE, 1000, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, M_PULSE, 1000, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, M_PULSE, 1000, 2, 0, 1000, 1));
        vecs.push_back(mk(1, 0, M_CONST, 200, 2, 0, 200, 1));
        vecs.push_back(mk(1, 1, M_CONST, 200, 2, 0, 0, 0));
        run_vecs("pulse");
        chk("clr.phase_cnt", int'(dut.phase_cnt), 0);
        vecs.push_back(mk(1, 0, M_CONST, 200, 2, 0, 200, 0));
        vecs.push_back(mk(1, 0, M_CONST, 200, 2, 0, 200, 1));
        vecs.push_back(mk(1, 0, M_ZERO, 200, 2, 0, 0, 1));
        vecs.push_back(mk(0, 1, M_ZERO, 200, 2, 0, 0, 0));
        run_vecs("clr");

        // Half period 0, full-scale CONST then SQUARE, then |diff|==slew
        do_reset();
        vecs.push_back(mk(1, 0, M_CONST, 32767, 0, 0, 32767, 1));
        vecs.push_back(mk(1, 0, M_CONST, 32767, 0, 0, 32767, 0));
        vecs.push_back(mk(1, 0, M_SQ, 32767, 0, 0, 32767, 1));
        vecs.push_back(mk(1, 0, M_SQ, 32767, 0, 0, -32767, 0));
        vecs.push_back(mk(1, 0, M_SQ, 32767, 0, 0, 32767, 1));
        vecs.push_back(mk(1, 0, M_SQ, 32767, 0, 0, -32767, 0));
        vecs.push_back(mk(1, 0, M_SQ, 32767, 0, 32767, 0, 1));
        vecs.push_back(mk(1, 0, M_SQ, 32767, 0, 32767, -32767, 0));
        run_vecs("fullscale");

        // Half period shortened below the current phase
        do_reset();
        for (int k = 0; k < 5; k++) vecs.push_back(mk(1, 0, M_SQ, 10, 8, 0, -10, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, M_SQ, 10, 3, 0, 10, 1));
        vecs.push_back(mk(1, 0, M_SQ, 10, 3, 0, -10, 0));
        run_vecs("hpchange");

        // Asynchronous reset mid-ramp
        do_reset();
        vecs.push_back(mk(1, 0, M_SQ, 200, 100, 40, -40, 0));
        vecs.push_back(mk(1, 0, M_SQ, 200, 100, 40, -80, 0));
        vecs.push_back(mk(1, 0, M_SQ, 200, 100, 40, -120, 0));
        run_vecs("ramp");
        #2;
        rstn = 1'b0;
        #1;
        aim = o_aim;
        chk("async.aim", aim, 0);
        chk("async.valid", int'(o_valid), 0);
        chk("async.dir", int'(o_dir), 0);
        @(negedge clk);
        rstn = 1'b1;
        vecs.push_back(mk(1, 0, M_SQ, 200, 100, 0, -200, 0));
        vecs.push_back(mk(1, 0, M_SQ, 200, 100, 0, -200, 0));
        run_vecs("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
